// File: rtl/lin_inv_monitor_if.sv
// Bundle between the linear-counter producer side and the invariant monitor.
// The master drives the producer strobe and register values; the slave reports the verdict.
interface lin_inv_monitor_if #(
   parameter int W  = 10,
   parameter int CW = 16
);
   logic          en;
   logic          step;
   logic [W-1:0]  x_in;
   logic [W-1:0]  y_in;
   logic          running;
   logic          failed;
   logic [2:0]    viol_code;
   logic [CW-1:0] fail_cycle;
   logic [CW-1:0] cyc_cnt;
   logic [CW-1:0] step_cnt;
   logic          y_wrap;

   modport master (
      output en, step, x_in, y_in,
      input  running, failed, viol_code, fail_cycle, cyc_cnt, step_cnt, y_wrap
   );

   modport slave (
      input  en, step, x_in, y_in,
      output running, failed, viol_code, fail_cycle, cyc_cnt, step_cnt, y_wrap
   );
endinterface

// File: rtl/lin_inv_monitor.sv
// On-chip invariant monitor for the x+=DX / y+=DY linear counter: shadows the producer and
// latches the first divergence or forbidden-state visit. Optional macro INV_MON_RESYNC_EN.
module lin_inv_monitor #(
   parameter int W     = 10,
   parameter int X0    = 2,
   parameter int Y0    = 0,
   parameter int DX    = 2,
   parameter int DY    = 1,
   parameter int BAD_X = 4,
   parameter int BAD_Y = 0,
   parameter int CW    = 16
) (
   input logic               clk,
   input logic               rst,
   lin_inv_monitor_if.slave  mon
);
   localparam logic [W-1:0]  X0_W    = W'(X0);
   localparam logic [W-1:0]  Y0_W    = W'(Y0);
   localparam logic [W-1:0]  DX_W    = W'(DX);
   localparam logic [W-1:0]  DY_W    = W'(DY);
   localparam logic [W-1:0]  BAD_X_W = W'(BAD_X);
   localparam logic [W-1:0]  BAD_Y_W = W'(BAD_Y);
   localparam logic [CW-1:0] ONE_CW  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FAIL = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  sx_q, sx_d;
   logic [W-1:0]  sy_q, sy_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [CW-1:0] stepCnt_q, stepCnt_d;
   logic [CW-1:0] failCyc_q, failCyc_d;
   logic [2:0]    viol_q, viol_d;
   logic          yWrap_q, yWrap_d;
   logic          mx, my, bd;
   logic [W:0]    yNextWide;

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      failCyc_d = failCyc_q;
      viol_d    = viol_q;
      stepCnt_d = mon.step ? stepCnt_q + ONE_CW : stepCnt_q;

      mx = (mon.x_in != sx_q);
      my = (mon.y_in != sy_q);
      bd = (mon.x_in == BAD_X_W) && (mon.y_in == BAD_Y_W);

      // The carry out of the y adder is the wrap indication for the shadow.
      yNextWide = {1'b0, sy_q} + {1'b0, DY_W};
      sx_d      = mon.step ? sx_q + DX_W : sx_q;
      sy_d      = mon.step ? yNextWide[W-1:0] : sy_q;
      yWrap_d   = mon.step & yNextWide[W];

      case (state_q)
         IDLE: begin
            if (mon.en) state_d = RUN;
         end
         RUN: begin
            if (cyc_q != '1) cyc_d = cyc_q + ONE_CW;
            if (mx || my || bd) begin
               state_d   = FAIL;
               viol_d    = {bd, my, mx};
               failCyc_d = cyc_q;
`ifdef INV_MON_RESYNC_EN
               // Re-align to what the producer will hold after this edge.
               yNextWide = {1'b0, mon.y_in} + (mon.step ? {1'b0, DY_W} : '0);
               sx_d      = mon.x_in + (mon.step ? DX_W : '0);
               sy_d      = yNextWide[W-1:0];
               yWrap_d   = mon.step & yNextWide[W];
`endif
            end else if (!mon.en) begin
               state_d = IDLE;
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sx_q      <= X0_W;
         sy_q      <= Y0_W;
         cyc_q     <= '0;
         stepCnt_q <= '0;
         failCyc_q <= '0;
         viol_q    <= '0;
         yWrap_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         cyc_q     <= cyc_d;
         stepCnt_q <= stepCnt_d;
         failCyc_q <= failCyc_d;
         viol_q    <= viol_d;
         yWrap_q   <= yWrap_d;
      end
   end

   assign mon.running    = (state_q == RUN);
   assign mon.failed     = (state_q == FAIL);
   assign mon.viol_code  = viol_q;
   assign mon.fail_cycle = failCyc_q;
   assign mon.cyc_cnt    = cyc_q;
   assign mon.step_cnt   = stepCnt_q;
   assign mon.y_wrap     = yWrap_q;
endmodule

// File: tb/tb_lin_inv_monitor.sv
// Self-checking bench for lin_inv_monitor: random producer traffic and fault injection
// checked against an arithmetic model of the counter and the monitor verdict.
module tb_lin_inv_monitor;
   localparam int W    = 10;
   localparam int CW   = 16;
   localparam int MODW = 1024;
   localparam int MODC = 65536;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lin_inv_monitor_if #(.W(W), .CW(CW)) bus ();
   lin_inv_monitor #(.W(W), .CW(CW)) dut (.clk(clk), .rst(rst), .mon(bus));

   int checks = 0;
   int failures = 0;
   int px = 2, py = 0;
   int mSx = 2, mSy = 0, mState = 0, mCyc = 0, mStep = 0, mFailCyc = 0, mViol = 0;
   bit mYWrap = 0;

   // Model: 0=idle 1=run 2=fail; shadow is plain modular arithmetic on step counts.
   task automatic modelEdge();
      int xi, yi, nSx, nSy, oldCyc;
      bit s, e, nW, vx, vy, vb;
      if (rst) begin
         mSx = 2; mSy = 0; mState = 0; mCyc = 0; mStep = 0; mFailCyc = 0; mViol = 0; mYWrap = 0;
      end else begin
         xi = int'(bus.x_in); yi = int'(bus.y_in); s = bus.step; e = bus.en;
         nSx = s ? (mSx + 2) % MODW : mSx;
         nSy = s ? (mSy + 1) % MODW : mSy;
         nW  = s && (mSy + 1 >= MODW);
         if (s) mStep = (mStep + 1) % MODC;
         if (mState == 0) begin
            if (e) mState = 1;
         end else if (mState == 1) begin
            vx = (xi != mSx); vy = (yi != mSy); vb = (xi == 4 && yi == 0);
            oldCyc = mCyc;
            if (mCyc < MODC - 1) mCyc = mCyc + 1;
            if (vx || vy || vb) begin
               mState = 2;
               mViol = (vb ? 4 : 0) + (vy ? 2 : 0) + (vx ? 1 : 0);
               mFailCyc = oldCyc;
`ifdef INV_MON_RESYNC_EN
               nSx = (xi + (s ? 2 : 0)) % MODW;
               nSy = (yi + (s ? 1 : 0)) % MODW;
               nW  = s && (yi + 1 >= MODW);
`endif
            end else if (!e) begin
               mState = 0;
            end
         end
         mSx = nSx; mSy = nSy; mYWrap = nW;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      if (rst) begin
         px = 2; py = 0;
      end else if (bus.step) begin
         px = (px + 2) % MODW; py = (py + 1) % MODW;
      end
      #1;
   endtask

   task automatic drive(input bit e, input bit s);
      bus.en = e; bus.step = s;
      bus.x_in = px[W-1:0]; bus.y_in = py[W-1:0];
   endtask

   task automatic doReset();
      rst = 1'b1; drive(0, 0); tick(); tick(); rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.en = 1'($urandom); bus.step = 1'($urandom);
         bus.x_in = W'($urandom); bus.y_in = W'($urandom);
         tick();
      end
      rst = 1'b0;
      checks++; if (bus.running !== 1'b0) begin failures++; $display("[TB] FAIL reset_running got=%b exp=0", bus.running); end
      checks++; if (bus.failed !== 1'b0) begin failures++; $display("[TB] FAIL reset_failed got=%b exp=0", bus.failed); end
      checks++; if (bus.viol_code !== 3'b000) begin failures++; $display("[TB] FAIL reset_viol got=%b exp=000", bus.viol_code); end
      checks++; if (bus.fail_cycle !== 16'd0) begin failures++; $display("[TB] FAIL reset_fail_cycle got=%0d exp=0", bus.fail_cycle); end
      checks++; if (bus.cyc_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_cyc got=%0d exp=0", bus.cyc_cnt); end
      checks++; if (bus.step_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_step_cnt got=%0d exp=0", bus.step_cnt); end
      checks++; if (bus.y_wrap !== 1'b0) begin failures++; $display("[TB] FAIL reset_y_wrap got=%b exp=0", bus.y_wrap); end
   endtask

   task automatic test_three_steps();
      doReset();
      drive(1, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1); tick();
         drive(1, 0); tick();
      end
      checks++; if (bus.failed !== 1'b0) begin failures++; $display("[TB] FAIL steps_failed got=%b exp=0", bus.failed); end
      checks++; if (bus.step_cnt !== 16'd3) begin failures++; $display("[TB] FAIL steps_step_cnt got=%0d exp=3", bus.step_cnt); end
      checks++; if (bus.running !== 1'b1) begin failures++; $display("[TB] FAIL steps_running got=%b exp=1", bus.running); end
      checks++; if (int'(bus.cyc_cnt) !== mCyc) begin failures++; $display("[TB] FAIL steps_cyc got=%0d exp=%0d", bus.cyc_cnt, mCyc); end
   endtask

   task automatic test_random_correct();
      doReset();
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 9) != 0), 1'($urandom)); tick();
         checks++;
         if ({bus.running, bus.failed, bus.y_wrap} !== {mState == 1, mState == 2, mYWrap}) begin
            failures++;
            $display("[TB] FAIL rand_flags cyc=%0d got=%b%b%b exp=%b%b%b", i, bus.running, bus.failed, bus.y_wrap, mState == 1, mState == 2, mYWrap);
         end
         checks++;
         if (int'(bus.cyc_cnt) !== mCyc || int'(bus.step_cnt) !== mStep) begin
            failures++;
            $display("[TB] FAIL rand_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bus.cyc_cnt, bus.step_cnt, mCyc, mStep);
         end
      end
   endtask

   task automatic test_bad_state();
      logic [2:0] code;
      logic [CW-1:0] fc, cc;
      doReset();
      drive(1, 0); tick();
      drive(1, 0); bus.x_in = 10'd4; bus.y_in = 10'd0; tick();
      checks++; if (bus.failed !== 1'b1) begin failures++; $display("[TB] FAIL bad_failed got=%b exp=1", bus.failed); end
      checks++; if (bus.viol_code !== 3'b101) begin failures++; $display("[TB] FAIL bad_viol got=%b exp=101", bus.viol_code); end
      checks++; if (int'(bus.fail_cycle) !== mFailCyc) begin failures++; $display("[TB] FAIL bad_fail_cycle got=%0d exp=%0d", bus.fail_cycle, mFailCyc); end
      checks++; if (int'(bus.cyc_cnt) !== mCyc) begin failures++; $display("[TB] FAIL bad_cyc got=%0d exp=%0d", bus.cyc_cnt, mCyc); end
      code = bus.viol_code; fc = bus.fail_cycle; cc = bus.cyc_cnt;
      for (int i = 0; i < 20; i++) begin
         bus.en = 1'($urandom); bus.step = 1'($urandom);
         bus.x_in = W'($urandom); bus.y_in = W'($urandom);
         tick();
         checks++;
         if ({bus.failed, bus.viol_code, bus.fail_cycle, bus.cyc_cnt} !== {1'b1, code, fc, cc}) begin
            failures++;
            $display("[TB] FAIL fail_frozen i=%0d got=%b/%b/%0d/%0d exp=1/%b/%0d/%0d", i, bus.failed, bus.viol_code, bus.fail_cycle, bus.cyc_cnt, code, fc, cc);
         end
      end
   endtask

   task automatic test_en_drop_violation();
      doReset();
      drive(1, 0); tick();
      for (int i = 0; i < 5; i++) begin drive(1, 1'($urandom)); tick(); end
      drive(0, 1'($urandom)); bus.y_in = W'((py + 1) % MODW); tick();
      checks++; if (bus.failed !== 1'b1 || bus.running !== 1'b0) begin failures++; $display("[TB] FAIL endrop_state got=%b%b exp=01", bus.running, bus.failed); end
      checks++; if (bus.viol_code !== 3'b010) begin failures++; $display("[TB] FAIL endrop_viol got=%b exp=010", bus.viol_code); end
      checks++; if (int'(bus.fail_cycle) !== mFailCyc) begin failures++; $display("[TB] FAIL endrop_fail_cycle got=%0d exp=%0d", bus.fail_cycle, mFailCyc); end
   endtask

   task automatic test_wrap();
      int wraps;
      int fails;
      doReset();
      drive(1, 0); tick();
      wraps = 0; fails = 0;
      for (int i = 0; i < 1023; i++) begin
         drive(1, 1); tick();
         if (bus.y_wrap === 1'b1) wraps++;
         if (bus.failed !== 1'b0) fails++;
      end
      checks++; if (wraps !== 0 || fails !== 0) begin failures++; $display("[TB] FAIL wrap_early got wraps=%0d fails=%0d exp=0/0", wraps, fails); end
      drive(1, 1); tick();
      checks++; if (bus.y_wrap !== 1'b1) begin failures++; $display("[TB] FAIL wrap_pulse got=%b exp=1", bus.y_wrap); end
      checks++; if (bus.step_cnt !== 16'd1024) begin failures++; $display("[TB] FAIL wrap_step_cnt got=%0d exp=1024", bus.step_cnt); end
      drive(1, 0); tick();
      checks++; if (bus.y_wrap !== 1'b0) begin failures++; $display("[TB] FAIL wrap_width got=%b exp=0", bus.y_wrap); end
      drive(1, 1); tick();
      drive(1, 0); tick();
      checks++; if (bus.failed !== 1'b0) begin failures++; $display("[TB] FAIL wrap_realign got=%b exp=0", bus.failed); end
   endtask

   task automatic test_idle_suppression();
      logic [CW-1:0] held;
      int bad;
      doReset();
      drive(1, 0); tick();
      for (int i = 0; i < 5; i++) begin drive(1, 1'($urandom)); tick(); end
      drive(0, 0); tick();
      checks++; if (bus.running !== 1'b0 || bus.failed !== 1'b0) begin failures++; $display("[TB] FAIL idle_drop got=%b%b exp=00", bus.running, bus.failed); end
      held = bus.cyc_cnt;
      checks++; if (int'(held) !== mCyc) begin failures++; $display("[TB] FAIL idle_cyc got=%0d exp=%0d", held, mCyc); end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         bus.en = 1'b0; bus.step = 1'($urandom);
         bus.x_in = W'(px + 1 + $urandom_range(0, 100)); bus.y_in = W'($urandom);
         tick();
         if (bus.failed !== 1'b0 || bus.running !== 1'b0 || bus.cyc_cnt !== held) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL idle_ignore got=%0d bad cycles exp=0", bad); end
   endtask

   task automatic test_rst_from_fail();
      int bad;
      doReset();
      drive(1, 0); tick();
      drive(1, 0); bus.x_in = 10'd4; bus.y_in = 10'd0; tick();
      rst = 1'b1; drive(1, 1); tick(); rst = 1'b0;
      checks++;
      if ({bus.running, bus.failed, bus.viol_code, bus.fail_cycle, bus.cyc_cnt, bus.step_cnt} !== '0) begin
         failures++;
         $display("[TB] FAIL rstfail_clear got=%b%b/%b/%0d/%0d/%0d exp=all zero", bus.running, bus.failed, bus.viol_code, bus.fail_cycle, bus.cyc_cnt, bus.step_cnt);
      end
      bad = 0;
      drive(1, 0); tick();
      for (int i = 0; i < 6; i++) begin
         drive(1, 1'($urandom)); tick();
         if (bus.failed !== 1'b0) bad++;
      end
      checks++; if (bad !== 0 || bus.running !== 1'b1) begin failures++; $display("[TB] FAIL rstfail_shadow got=%0d fails run=%b exp=0 run=1", bad, bus.running); end
   endtask

   task automatic test_resync();
      int wraps;
      int bad;
      px = 100; py = 49;
      drive(1, 0); tick();
      checks++; if (bus.failed !== 1'b1) begin failures++; $display("[TB] FAIL resync_failed got=%b exp=1", bus.failed); end
      checks++; if (int'(bus.viol_code) !== mViol) begin failures++; $display("[TB] FAIL resync_viol got=%b exp=%0d", bus.viol_code, mViol); end
      wraps = 0; bad = 0;
      for (int i = 0; i < 1030; i++) begin
         drive(1, 1); tick();
         if (bus.y_wrap !== mYWrap) bad++;
         if (bus.y_wrap === 1'b1) wraps++;
      end
      checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL resync_wrap_timing got=%0d wrong cycles exp=0", bad); end
      checks++; if (wraps !== 1) begin failures++; $display("[TB] FAIL resync_wrap_count got=%0d exp=1", wraps); end
      checks++; if (bus.failed !== 1'b1 || int'(bus.viol_code) !== mViol) begin failures++; $display("[TB] FAIL resync_sticky got=%b/%b exp=1/%0d", bus.failed, bus.viol_code, mViol); end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0);
      test_reset();
      test_three_steps();
      test_random_correct();
      test_bad_state();
      test_en_drop_violation();
      test_wrap();
      test_idle_suppression();
      test_rst_from_fail();
      test_resync();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
